slurm16_cpu_mem_port: RTL
=========================

Name: slurm16_cpu_mem_port

Overview:
- Memory-side responder for the execute stage's load/store request signals.
- Captures a load or store request and freezes the pipeline with a stall.
- Runs the request as a valid/ready transaction on the external data-memory bus, then returns load data to writeback.
- Sits between the execute stage and the data memory / bus arbiter. It includes a timeout so a dead bus cannot hang the CPU.

Parameters:
- BITS, 16, data width
- ADDRESS_BITS, 16, address width
- REGISTER_BITS, 4, destination register index width
- TIMEOUT_CYCLES, 255, max cycles in ISSUE+WAIT_DATA before abort (1..255)

Ports:
- CLK  input  1  clock
- RSTb  input  1  synchronous, active-low reset
- load_memory  input  1  load request from execute
- store_memory  input  1  store request from execute
- load_store_address  input  ADDRESS_BITS  request address
- memory_out  input  BITS  store data
- dest_reg  input  REGISTER_BITS  load destination register
- stall  output  1  freeze pipeline
- wb_valid  output  1  one-cycle pulse: load result valid
- wb_data  output  BITS  load result
- wb_reg  output  REGISTER_BITS  load destination
- bus_error  output  1  one-cycle pulse: timeout abort or illegal request
- bus_valid  output  1  bus request valid
- bus_wr  output  1  1 = write, 0 = read
- bus_addr  output  ADDRESS_BITS  bus address
- bus_wdata  output  BITS  bus write data
- bus_ready  input  1  bus accepts request
- bus_rvalid  input  1  read data valid
- bus_rdata  input  BITS  read data

Behaviour:
- Reset (RSTb=0 at a CLK edge):
  - State goes to IDLE; timeout counter goes to 0.
  - All registered outputs go to 0: bus_valid, bus_wr, bus_addr, bus_wdata, wb_valid, wb_data, wb_reg, bus_error.
  - Reset mid-transaction abandons the transaction; bus_valid is low the cycle after the reset edge. Any late bus_rvalid after that is ignored.
- States: IDLE, ISSUE, WAIT_DATA, DONE.
- Request accepted in IDLE only, when (load_memory | store_memory):
  - Capture address, data, dest_reg and type into bus_addr/bus_wdata/wb_reg/bus_wr.
  - Move to ISSUE; counter is cleared.
  - Both load_memory and store_memory high: the store is taken, and bus_error pulses in the cycle after capture.
- stall is combinational: 1 when state is ISSUE or WAIT_DATA, or when state is IDLE and a request is present. stall is 0 in DONE and in IDLE with no request.
- ISSUE:
  - bus_valid=1; counter increments each cycle.
  - On bus_ready=1: drop bus_valid next cycle. A store goes to DONE; a load goes to WAIT_DATA.
  - bus_addr/bus_wr/bus_wdata are held stable while bus_valid=1.
- WAIT_DATA:
  - Counter keeps incrementing.
  - On bus_rvalid=1: wb_data<=bus_rdata and go to DONE.
  - bus_rvalid is accepted in the same cycle as bus_ready (zero-latency memory): a load then goes directly ISSUE->DONE with data captured.
- Timeout: in ISSUE or WAIT_DATA, the counter reaching TIMEOUT_CYCLES with no completing handshake causes:
  - go to DONE and drop bus_valid;
  - bus_error pulses during DONE;
  - for a load, wb_data=16'hFFFF.
- DONE (exactly one cycle):
  - wb_valid=1 for loads only; 0 for stores.
  - load_memory/store_memory are ignored in this cycle, because the pipeline still presents the just-completed request; DONE always returns to IDLE.
  - wb_valid and bus_error are 0 outside DONE.
- Latency with bus_ready/bus_rvalid always high:
  - store: capture at T0 (IDLE, stall=1), T1 ISSUE, T2 DONE (stall=0), T3 IDLE;
  - load: identical, with wb_valid at T2.
- Counter width is 8 bits. It never wraps, because the abort occurs at TIMEOUT_CYCLES.
- No pipelining: a single outstanding transaction.

Test Plan:
1. Store, zero-wait bus: store_memory=1, addr=16'h1234, data=16'hBEEF, bus_ready=1 -> one bus_valid cycle with bus_wr=1, addr 1234, wdata BEEF; stall high for 2 cycles; wb_valid never asserts; back to IDLE at T3.
2. Load with wait states: load_memory=1, addr=16'h0040, dest_reg=5; bus_ready after 3 cycles; bus_rvalid with rdata=16'hA5A5 after 2 more cycles -> bus_valid held 3 cycles with address stable; wb_valid pulse with wb_data=A5A5, wb_reg=5; stall low in the same cycle.
3. Request held through DONE: keep load_memory=1 continuously -> exactly one bus transaction per IDLE entry, with no duplicate issued from DONE.
4. Timeout: TIMEOUT_CYCLES=4, load with bus_ready stuck 0 -> bus_valid for 4 cycles then low; DONE with bus_error=1, wb_valid=1, wb_data=FFFF.
5. Illegal request: load_memory=store_memory=1 -> write transaction issued; bus_error pulse in the cycle after capture.
6. Reset mid-op: assert RSTb=0 during WAIT_DATA, then return bus_rvalid -> next cycle all outputs 0 and state IDLE; the late rvalid produces no wb_valid.

Source files
------------

// File: rtl/slurm16_cpu_mem_port.sv
// Memory-side responder for execute-stage loads/stores: stalls the pipeline,
// runs one valid/ready bus transaction with a timeout, and returns load data.
module slurm16_cpu_mem_port #(
  parameter int BITS           = 16,
  parameter int ADDRESS_BITS   = 16,
  parameter int REGISTER_BITS  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     CLK,
  input  logic                     RSTb,
  input  logic                     load_memory,
  input  logic                     store_memory,
  input  logic [ADDRESS_BITS-1:0]  load_store_address,
  input  logic [BITS-1:0]          memory_out,
  input  logic [REGISTER_BITS-1:0] dest_reg,
  output logic                     stall,
  output logic                     wb_valid,
  output logic [BITS-1:0]          wb_data,
  output logic [REGISTER_BITS-1:0] wb_reg,
  output logic                     bus_error,
  output logic                     bus_valid,
  output logic                     bus_wr,
  output logic [ADDRESS_BITS-1:0]  bus_addr,
  output logic [BITS-1:0]          bus_wdata,
  input  logic                     bus_ready,
  input  logic                     bus_rvalid,
  input  logic [BITS-1:0]          bus_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                   state_q, state_d;
  logic [7:0]               cnt_q, cnt_d;
  logic                     bus_valid_q, bus_valid_d;
  logic                     bus_wr_q, bus_wr_d;
  logic [ADDRESS_BITS-1:0]  bus_addr_q, bus_addr_d;
  logic [BITS-1:0]          bus_wdata_q, bus_wdata_d;
  logic                     wb_valid_q, wb_valid_d;
  logic [BITS-1:0]          wb_data_q, wb_data_d;
  logic [REGISTER_BITS-1:0] wb_reg_q, wb_reg_d;
  logic                     bus_error_q, bus_error_d;
  logic                     req;
  logic                     timeout_hit;

  assign req         = load_memory | store_memory;
  assign timeout_hit = (cnt_q >= CNT_LAST);

  assign stall = (state_q == ISSUE) || (state_q == WAIT_DATA) ||
                 ((state_q == IDLE) && req);

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bus_valid_q <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_reg_q    <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_valid_q <= bus_valid_d;
      bus_wr_q    <= bus_wr_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_reg_q    <= wb_reg_d;
      bus_error_q <= bus_error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_valid_d = bus_valid_q;
    bus_wr_d    = bus_wr_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    wb_data_d   = wb_data_q;
    wb_reg_d    = wb_reg_q;
    wb_valid_d  = 1'b0;
    bus_error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          // A simultaneous load+store is resolved as a store and flagged.
          bus_addr_d  = load_store_address;
          bus_wdata_d = memory_out;
          wb_reg_d    = dest_reg;
          bus_wr_d    = store_memory;
          bus_error_d = load_memory & store_memory;
          bus_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = cnt_q + 8'd1;
        if (bus_ready) begin
          bus_valid_d = 1'b0;
          if (bus_wr_q) begin
            state_d = DONE;
          end else if (bus_rvalid) begin
            wb_data_d  = bus_rdata;
            wb_valid_d = 1'b1;
            state_d    = DONE;
          end else begin
            state_d = WAIT_DATA;
          end
        end else if (timeout_hit) begin
          bus_valid_d = 1'b0;
          bus_error_d = 1'b1;
          if (!bus_wr_q) begin
            wb_data_d  = '1;
            wb_valid_d = 1'b1;
          end
          state_d = DONE;
        end
      end
      WAIT_DATA: begin
        cnt_d = cnt_q + 8'd1;
        if (bus_rvalid) begin
          wb_data_d  = bus_rdata;
          wb_valid_d = 1'b1;
          state_d    = DONE;
        end else if (timeout_hit) begin
          wb_data_d   = '1;
          wb_valid_d  = 1'b1;
          bus_error_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        // The pipeline still shows the finished request here; never re-issue it.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_valid = bus_valid_q;
  assign bus_wr    = bus_wr_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_data   = wb_data_q;
  assign wb_reg    = wb_reg_q;
  assign bus_error = bus_error_q;

endmodule
